phase_decimator: RTL

//  Downstream of the phasemeter loop. Consumes the wrapped phase-error/phase word
//  (one strobe per CIC decimated sample) and unwraps it as successive differences.

---
 rtl/phase_decimator.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/phase_decimator.sv
// phase_decimator: unwraps a wrapped phase stream by successive differences, averages
// 2^LOG2_DEC differences into a mean frequency word, and queues results in a
// first-word-fall-through FIFO behind an AXI-Stream master.
// Optional build macro ROUND_EN: round the mean half toward +inf instead of truncating.
module phase_decimator #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LOG2_DEC   = 10,
  parameter int unsigned FIFO_AW    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [FIFO_AW:0]      fifo_level,
  output logic [15:0]           ovf_count
);

  localparam int unsigned SumW  = DATA_WIDTH + LOG2_DEC;
  localparam int unsigned Depth = 2 ** FIFO_AW;

  typedef enum logic {StSeed, StRun} state_e;

  state_e r_state, w_state_d;

  logic [DATA_WIDTH-1:0]  r_prev;
  logic signed [SumW-1:0] r_sum;
  logic [LOG2_DEC-1:0]    r_cnt;
  logic [DATA_WIDTH-1:0]  r_res;
  logic                   r_res_vld;

  logic [DATA_WIDTH-1:0]  r_mem [Depth];
  logic [FIFO_AW:0]       r_wptr, r_rptr;
  logic [DATA_WIDTH-1:0]  r_last;
  logic [15:0]            r_ovf;

  logic [DATA_WIDTH-1:0]  w_delta;
  logic signed [SumW-1:0] w_acc;
  logic [DATA_WIDTH-1:0]  w_res;
  logic                   w_close;
  logic [FIFO_AW:0]       w_level;
  logic                   w_empty, w_full, w_pop, w_push_req, w_push, w_drop;

  // Modulo difference: a wrap of the phase word still yields the small true step.
  assign w_delta = s_axis_tdata - r_prev;
  assign w_acc   = r_sum + $signed({{LOG2_DEC{w_delta[DATA_WIDTH-1]}}, w_delta});
  assign w_close = (r_cnt == '1);

`ifdef ROUND_EN
  localparam logic [SumW:0] RndHalf = (SumW + 1)'(1) << (LOG2_DEC - 1);
  logic signed [SumW:0] w_rnd;
  assign w_rnd = $signed({w_acc[SumW-1], w_acc} + RndHalf);
  assign w_res = w_rnd[SumW-1:LOG2_DEC];
`else
  // Upper slice of the sum is the arithmetic shift truncated to DATA_WIDTH.
  assign w_res = w_acc[SumW-1:LOG2_DEC];
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= StSeed;
    else     r_state <= w_state_d;
  end

  // Next state: disabling returns to seeding; the first strobe only seeds.
  always_comb begin
    w_state_d = r_state;
    if (!en) begin
      w_state_d = StSeed;
    end else if (s_axis_tvalid && r_state == StSeed) begin
      w_state_d = StRun;
    end
  end

  // Accumulate deltas; on the window-closing strobe register the mean and restart.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev    <= '0;
      r_sum     <= '0;
      r_cnt     <= '0;
      r_res     <= '0;
      r_res_vld <= 1'b0;
    end else begin
      r_res_vld <= 1'b0;
      if (!en) begin
        r_sum <= '0;
        r_cnt <= '0;
      end else if (s_axis_tvalid) begin
        r_prev <= s_axis_tdata;
        if (r_state == StRun) begin
          r_cnt <= r_cnt + 1'b1;
          if (w_close) begin
            r_sum     <= '0;
            r_res     <= w_res;
            r_res_vld <= 1'b1;
          end else begin
            r_sum <= w_acc;
          end
        end
      end
    end
  end

  assign w_level    = r_wptr - r_rptr;
  assign w_empty    = (w_level == '0);
  assign w_full     = (w_level == (FIFO_AW + 1)'(Depth));
  assign w_pop      = !w_empty && m_axis_tready;
  // A result still pending when en drops is discarded.
  assign w_push_req = r_res_vld && en;
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_drop     = w_push_req && w_full && !w_pop;

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[FIFO_AW-1:0]] <= r_res;
  end

  // FIFO pointers, last-popped word and saturating overflow counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_last <= '0;
      r_ovf  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
        r_last <= r_mem[r_rptr[FIFO_AW-1:0]];
      end
      if (w_drop && r_ovf != 16'hFFFF) r_ovf <= r_ovf + 16'd1;
    end
  end

  assign m_axis_tvalid = !w_empty;
  assign m_axis_tdata  = w_empty ? r_last : r_mem[r_rptr[FIFO_AW-1:0]];
  assign fifo_level    = w_level;
  assign ovf_count     = r_ovf;

endmodule
